// File: rtl/simt_banked_dmem.sv
// simt_banked_dmem
//   Banked per-lane data memory for the SIMT load/store port. The block takes
//   one warp-wide request at a time. It spreads the lanes over NUM_BANKS
//   single-ported banks and serializes lanes that conflict in a bank. Loads
//   to the same full address share one broadcast serve cycle. The block then
//   returns one warp-wide response.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only in IDLE)
//   i_req_we              1 = store on all active lanes, 0 = load
//   i_req_mask            active lanes
//   i_req_addr/i_req_wdata per-lane word address / store data
//   o_rsp_valid/i_rsp_ready  response handshake (valid only in RESP)
//   o_rsp_rdata           per-lane load data (zero for stores, masked lanes)
//   o_conflict_cnt        saturating count of serve cycles beyond the first

module simt_banked_dmem #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_BANKS   = 4,
    parameter int BANK_DEPTH  = 256
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_req_valid,
    output logic                                   o_req_ready,
    input  logic                                   i_req_we,
    input  logic [NUM_THREADS-1:0]                 i_req_mask,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] i_req_addr,
    input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] i_req_wdata,
    output logic                                   o_rsp_valid,
    input  logic                                   i_rsp_ready,
    output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [15:0]                            o_conflict_cnt
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam int RW = $clog2(BANK_DEPTH);
    localparam int LW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    // state   | meaning
    // S_IDLE  | ready for a request
    // S_SERVE | draining pending lanes, one group per bank per cycle
    // S_RESP  | response held until the consumer takes it
    typedef enum logic [1:0] {S_IDLE, S_SERVE, S_RESP} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                                   r_we;
    logic [NUM_THREADS-1:0]                 r_pending;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_addr;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_wdata;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] r_rdata;
    logic [15:0]                            r_cnt;
    logic                                   r_first;

    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][BANK_DEPTH];

    logic [NUM_BANKS-1:0]   w_win_valid;
    logic [LW-1:0]          w_win_lane [NUM_BANKS];
    logic [RW-1:0]          w_win_row  [NUM_BANKS];
    logic [DATA_WIDTH-1:0]  w_rd_word  [NUM_BANKS];
    logic [NUM_THREADS-1:0] w_served;
    logic [NUM_THREADS-1:0] w_pending_nxt;

    // The loop scans from the top lane down, so the lowest pending lane in
    // each bank is written last and becomes that bank's winner.
    always_comb begin
        w_win_valid = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_win_lane[b] = '0;
        end
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (r_pending[t]) begin
                w_win_valid[r_addr[t][BW-1:0]] = 1'b1;
                w_win_lane[r_addr[t][BW-1:0]]  = LW'(t);
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_win_row[b] = r_addr[w_win_lane[b]][BW +: RW];
            w_rd_word[b] = r_mem[b][w_win_row[b]];
        end
    end

    // A load is served together with every pending lane that carries the
    // same full address as its bank's winner. Aliased addresses that only
    // share a row still take separate cycles. A store serves only the winner.
    always_comb begin
        w_served = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (r_pending[t]) begin
                if (r_we) begin
                    w_served[t] = (w_win_lane[r_addr[t][BW-1:0]] == LW'(t));
                end else begin
                    w_served[t] = (r_addr[t] == r_addr[w_win_lane[r_addr[t][BW-1:0]]]);
                end
            end
        end
        w_pending_nxt = r_pending & ~w_served;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = (i_req_mask != '0) ? S_SERVE : S_RESP;
                end
            end
            S_SERVE: begin
                if (w_pending_nxt == '0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            r_rdata   <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_we      <= i_req_we;
                        r_addr    <= i_req_addr;
                        r_wdata   <= i_req_wdata;
                        r_pending <= i_req_mask;
                        r_rdata   <= '0;
                        r_first   <= 1'b1;
                    end
                end
                S_SERVE: begin
                    r_pending <= w_pending_nxt;
                    r_first   <= 1'b0;
                    if (!r_first && r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (!r_we) begin
                        for (int t = 0; t < NUM_THREADS; t++) begin
                            if (w_served[t]) begin
                                r_rdata[t] <= w_rd_word[r_addr[t][BW-1:0]];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bank contents are not reset. Writes are only held off while reset is
    // asserted, so data that was already committed survives a reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && r_state == S_SERVE && r_we) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_win_valid[b]) begin
                    r_mem[b][w_win_row[b]] <= r_wdata[w_win_lane[b]];
                end
            end
        end
    end

    assign o_req_ready    = (r_state == S_IDLE);
    assign o_rsp_valid    = (r_state == S_RESP);
    assign o_rsp_rdata    = r_rdata;
    assign o_conflict_cnt = r_cnt;

endmodule

// File: tb/tb_simt_banked_dmem.sv
module tb_simt_banked_dmem;

    localparam int NT = 4;
    localparam int DW = 16;
    localparam int NB = 4;
    localparam int MW = 10;    // log2(NB * 256): words of unaliased storage

    typedef logic [NT-1:0][DW-1:0] vec_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [NT-1:0] i_req_mask;
    vec_t        i_req_addr;
    vec_t        i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    vec_t        o_rsp_rdata;
    logic [15:0] o_conflict_cnt;

    simt_banked_dmem #(
        .NUM_THREADS(NT), .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(256)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_mask(i_req_mask),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_conflict_cnt(o_conflict_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: one flat word array indexed by the address modulo
    // the total capacity.
    logic [DW-1:0] mdl [1 << MW];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve cycles needed: in every bank, count the distinct address groups.
    // A store counts each lane, and a load counts each distinct full address.
    // The busiest bank sets the total.
    function automatic int calc_k(input logic we, input logic [NT-1:0] mask, input vec_t addr);
        int k = 0;
        for (int b = 0; b < NB; b++) begin
            int groups = 0;
            for (int t = 0; t < NT; t++) begin
                if (mask[t] && (int'(addr[t]) % NB) == b) begin
                    bit dup = 0;
                    if (!we) begin
                        for (int u = 0; u < t; u++) begin
                            if (mask[u] && addr[u] == addr[t]) dup = 1;
                        end
                    end
                    if (!dup) groups++;
                end
            end
            if (groups > k) k = groups;
        end
        return k;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [NT-1:0] mask,
                          input vec_t addr, input vec_t wdata, input int hold);
        vec_t        exp_data;
        int          k;
        int          cyc;
        logic [15:0] cnt0;
        k = calc_k(we, mask, addr);
        exp_data = '0;
        for (int t = 0; t < NT; t++) begin
            if (mask[t]) begin
                if (we) mdl[addr[t][MW-1:0]] = wdata[t];
                else    exp_data[t] = mdl[addr[t][MW-1:0]];
            end
        end
        cnt0 = o_conflict_cnt;
        chk({tag, " idle_ready"}, 64'(o_req_ready), 64'd1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_mask  = mask;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_req_addr  = vec_t'($urandom);
        cyc = 1;
        chk({tag, " busy_ready"}, 64'(o_req_ready), 64'd0);
        while (!o_rsp_valid && cyc < 64) begin
            @(negedge i_clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(k + 1));
        chk({tag, " rdata"}, 64'(o_rsp_rdata), 64'(exp_data));
        chk({tag, " conflicts"}, 64'(16'(o_conflict_cnt - cnt0)), 64'((k > 0) ? k - 1 : 0));
        for (int h = 0; h < hold; h++) begin
            @(negedge i_clk);
            chk({tag, " hold_valid"}, 64'(o_rsp_valid), 64'd1);
            chk({tag, " hold_rdata"}, 64'(o_rsp_rdata), 64'(exp_data));
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        chk({tag, " post_valid"}, 64'(o_rsp_valid), 64'd0);
    endtask

    initial begin
        vec_t a;
        vec_t d;
        logic [15:0] cnt0;
        i_rst       = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_req_mask  = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_rsp_ready = 1'b0;

        // Reset for two cycles.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst ready", 64'(o_req_ready), 64'd1);
        chk("rst valid", 64'(o_rsp_valid), 64'd0);
        chk("rst rdata", 64'(o_rsp_rdata), 64'd0);
        chk("rst cnt", 64'(o_conflict_cnt), 64'd0);

        // Fill every word so that later loads have known contents.
        for (int i = 0; i < (1 << MW) / NT; i++) begin
            for (int t = 0; t < NT; t++) begin
                a[t] = 16'(i * NT + t);
                d[t] = 16'($urandom);
            end
            do_req("fill", 1'b1, 4'hF, a, d, 0);
        end

        // Conflict-free store, then load.
        a = {16'd3, 16'd2, 16'd1, 16'd0};
        d = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        do_req("st0123", 1'b1, 4'hF, a, d, 0);
        do_req("ld0123", 1'b0, 4'hF, a, '0, 0);
        chk("ld0123 const", 64'(o_rsp_rdata), 64'h00A3_00A2_00A1_00A0);

        // Full bank conflict.
        a = {16'd12, 16'd8, 16'd4, 16'd0};
        d = {16'h13, 16'h12, 16'h11, 16'h10};
        do_req("st_conf", 1'b1, 4'hF, a, d, 0);
        do_req("ld_conf", 1'b0, 4'hF, a, '0, 0);

        // Broadcast load, then same-address store.
        do_req("st5", 1'b1, 4'b0010, {16'd0, 16'd0, 16'd5, 16'd0}, {16'd0, 16'd0, 16'h55, 16'd0}, 0);
        do_req("bcast5", 1'b0, 4'hF, {4{16'd5}}, '0, 0);
        do_req("st7", 1'b1, 4'hF, {4{16'd7}}, {16'd4, 16'd3, 16'd2, 16'd1}, 0);
        do_req("ld7", 1'b0, 4'hF, {4{16'd7}}, '0, 0);
        chk("ld7 const", 64'(o_rsp_rdata), 64'h0004_0004_0004_0004);

        // Mask, alias and back-pressure (restore words 0..3 first).
        do_req("st0123b", 1'b1, 4'hF, {16'd3, 16'd2, 16'd1, 16'd0},
               {16'hA3, 16'hA2, 16'hA1, 16'hA0}, 0);
        do_req("alias", 1'b0, 4'b0101, {16'hFFFF, 16'h0002, 16'hFFFF, 16'h0400}, '0, 3);
        chk("alias const", 64'(o_rsp_rdata), 64'h0000_00A2_0000_00A0);

        // Empty mask.
        do_req("empty", 1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, '0, 1);

        // Reset in the second serve cycle of a four-way conflict load.
        cnt0 = o_conflict_cnt;
        chk("mid precnt", 64'(cnt0 != 16'd0), 64'd1);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_mask  = 4'hF;
        i_req_addr  = {16'd12, 16'd8, 16'd4, 16'd0};
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("midrst ready", 64'(o_req_ready), 64'd1);
        chk("midrst valid", 64'(o_rsp_valid), 64'd0);
        chk("midrst cnt", 64'(o_conflict_cnt), 64'd0);
        chk("midrst rdata", 64'(o_rsp_rdata), 64'd0);
        do_req("after_rst", 1'b0, 4'hF, {16'd12, 16'd8, 16'd4, 16'd0}, '0, 0);

        // Randomized traffic over a small pool of words, with aliasing.
        for (int i = 0; i < 80; i++) begin
            for (int t = 0; t < NT; t++) begin
                a[t] = 16'($urandom_range(0, 23));
                if ($urandom_range(0, 3) == 0) a[t] = a[t] | (16'($urandom) & 16'hFC00);
                d[t] = 16'($urandom);
            end
            do_req("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, d,
                   int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
